modexp_sequencer: RTL and testbench

Sequencer that computes base^exp mod MOD by driving one shared combinational modulo-47 multiplier with left-to-right square-and-multiply. It sits between a valid/ready request source and the existing modular multiplier instance. The block owns the accumulator, exponent and bit counter, and issues exactly one multiply per clock. It never instantiates the multiplier itself. The multiplier operand/result ports are exposed so the top level wires them to the shared unit.

---
 rtl/modexp_pkg.sv | 10 +
 rtl/modexp_fsm.sv | 60 ++++++
 rtl/modexp_sequencer.sv | 62 ++++++
 tb/tb_modexp_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// modexp_pkg: shared state encoding, default parameters and residue helper for modexp_sequencer.
package modexp_pkg;
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_e;
  localparam int DEF_MOD = 47;
  localparam int DEF_W   = 6;
  localparam int DEF_EW  = 8;
  function automatic int reduce_once(input int x, input int m);
    return x >= m ? x - m : x;
  endfunction
endpackage

// File: rtl/modexp_fsm.sv
// modexp_fsm: square-and-multiply schedule (state + bit counter); MODEXP_CONST_TIME_EN forces SQR->MUL every bit.
module modexp_fsm import modexp_pkg::*; #(
  parameter int EW = DEF_EW,
  parameter int CW = EW > 1 ? $clog2(EW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ebit,
  input  logic          out_ready,
  output state_e        state,
  output logic [CW-1:0] cnt,
  output logic          in_ready,
  output logic          out_valid
);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SQR;
        cnt_d   = CW'(EW - 1);
      end
`ifdef MODEXP_CONST_TIME_EN
      SQR: state_d = MUL;
`else
      SQR: if (ebit) state_d = MUL;
           else if (cnt_q == '0) state_d = DONE;
           else cnt_d = cnt_q - 1'b1;
`endif
      MUL: if (cnt_q == '0) state_d = DONE;
           else begin
             cnt_d   = cnt_q - 1'b1;
             state_d = SQR;
           end
      default: if (out_ready) state_d = IDLE;
    endcase
  end
  always_comb begin
    state     = state_q;
    cnt       = cnt_q;
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end
`ifdef MODEXP_CONST_TIME_EN
  logic unused_ebit;
  assign unused_ebit = ebit;
`endif
endmodule

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: base^exp mod MOD via left-to-right square-and-multiply on an external shared multiplier (MODEXP_CONST_TIME_EN: fixed 2*EW latency).
module modexp_sequencer import modexp_pkg::*; #(
  parameter int MOD = DEF_MOD,
  parameter int W   = DEF_W,
  parameter int EW  = DEF_EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic [W-1:0]  mul_a,
  output logic [W-1:0]  mul_b,
  input  logic [W-1:0]  mul_r
);
  localparam int CW = EW > 1 ? $clog2(EW) : 1;
  state_e state;
  logic [CW-1:0] cnt;
  logic accept, ebit, busy;
  logic [W-1:0] acc_q, acc_d, b_q, b_d;
  logic [EW-1:0] e_q, e_d;
  assign accept = in_valid && in_ready;
  assign ebit   = e_q[cnt];
  assign busy   = state == SQR || state == MUL;
  modexp_fsm #(.EW(EW), .CW(CW)) u_fsm (
    .clk(clk), .rst(rst), .start(in_valid), .ebit(ebit), .out_ready(out_ready),
    .state(state), .cnt(cnt), .in_ready(in_ready), .out_valid(out_valid)
  );
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    e_d   = e_q;
    if (accept) begin
      acc_d = W'(1);
      b_d   = W'(reduce_once(int'(base), MOD));
      e_d   = exp;
    end else if (state == SQR) acc_d = mul_r;
`ifdef MODEXP_CONST_TIME_EN
    else if (state == MUL) acc_d = ebit ? mul_r : acc_q;
`else
    else if (state == MUL) acc_d = mul_r;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      e_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      e_q   <= e_d;
    end
  end
  assign mul_a  = busy ? acc_q : '0;
  assign mul_b  = state == SQR ? acc_q : state == MUL ? b_q : '0;
  assign result = acc_q;
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed table, corner sequences and random requests against an arithmetic modpow model.
module tb_modexp_sequencer;
  localparam int MOD = 47, W = 6, EW = 8;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] base_i = 0, result, mul_a, mul_b, mul_r;
  logic [EW-1:0] exp_i = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign mul_r = W'((int'(mul_a) * int'(mul_b)) % MOD);
  modexp_sequencer #(.MOD(MOD), .W(W), .EW(EW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .base(base_i), .exp(exp_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r)
  );
  typedef struct {int b; int e; int res; int lat;} vec_t;
  function automatic int modpow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % MOD)) % MOD;
    return r;
  endfunction
  function automatic int lat(input int e);
`ifdef MODEXP_CONST_TIME_EN
    return 2 * EW;
`else
    return EW + $countones(e[EW-1:0]);
`endif
  endfunction
  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic run(input int bs, input int ex, input int hold, output int res, output int cyc, output int nz);
    @(negedge clk);
    base_i = W'(bs);
    exp_i = EW'(ex);
    in_valid = 1;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
    cyc = 0;
    nz = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      if (mul_a != 0) nz++;
      @(posedge clk);
      #1 cyc++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    res = int'(result);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1;
      base_i = 7;
      exp_i = 3;
      chk("hold_result", int'(result), res);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1 in_valid = 0;
    end
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("idle_after_hs", int'(in_ready), 1);
    chk("valid_drop_after_hs", int'(out_valid), 0);
  endtask
  initial begin
    vec_t tab[6];
    int res, cyc, nz, b, e;
    tab[0] = '{2, 5, 32, lat(5)};
    tab[1] = '{45, 15, 38, lat(15)};
    tab[2] = '{5, 0, 1, lat(0)};
    tab[3] = '{3, 46, 1, lat(46)};
    tab[4] = '{50, 2, 9, lat(2)};
    tab[5] = '{47, 3, 0, lat(3)};
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_result", int'(result), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    @(negedge clk) rst = 0;
    foreach (tab[i]) begin
      run(tab[i].b, tab[i].e, 0, res, cyc, nz);
      chk($sformatf("tab%0d_result", i), res, tab[i].res);
      chk($sformatf("tab%0d_latency", i), cyc, tab[i].lat);
      if (i == 0) chk("tab0_mul_cycles", nz, tab[0].lat);
    end
    run(2, 5, 5, res, cyc, nz);
    chk("hold_seq_result", res, 32);
    repeat (3) @(negedge clk);
    chk("no_spurious_accept", int'(in_ready), 1);
    @(negedge clk);
    base_i = 45;
    exp_i = 15;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1 chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_mul_a", int'(mul_a), 0);
    chk("midrst_result", int'(result), 0);
    @(negedge clk) rst = 0;
    #1 chk("midrst_in_ready", int'(in_ready), 1);
    run(2, 5, 0, res, cyc, nz);
    chk("post_rst_result", res, 32);
    chk("post_rst_latency", cyc, lat(5));
    for (int i = 0; i < 30; i++) begin
      b = int'($urandom_range(0, 63));
      e = int'($urandom_range(0, 255));
      run(b, e, int'($urandom_range(0, 2)), res, cyc, nz);
      chk($sformatf("rand_result b=%0d e=%0d", b, e), res, modpow(b, e));
      chk($sformatf("rand_latency e=%0d", e), cyc, lat(e));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
